// File: rtl/rps_move_sequencer_pkg.sv
// Shared types for the rock-paper-scissors move sequencer.
//   move_e         : 2-bit move encoding (NONE is illegal on the push ports)
//   seq_state_e    : round sequencer FSM states
//   move_to_onehot : move -> {r, p, s} one-hot, all zero for NONE
package rps_types_pkg;

   typedef enum logic [1:0] {
      NONE     = 2'b00,
      ROCK     = 2'b01,
      PAPER    = 2'b10,
      SCISSORS = 2'b11
   } move_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_ISSUE     = 2'b01,
      ST_WAIT_BUSY = 2'b10,
      ST_WAIT_DONE = 2'b11
   } seq_state_e;

   // Bit order is {r, p, s}.
   function automatic logic [2:0] move_to_onehot(input move_e mv);
      logic [2:0] oh;
      case (mv)
         ROCK:     oh = 3'b100;
         PAPER:    oh = 3'b010;
         SCISSORS: oh = 3'b001;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rps_move_sequencer_if.sv
// Handshake bundle between the move source / scoring DUT and the sequencer.
//   push1_* / push2_* : per-player valid/ready move push ports
//   dut_busy          : scoring DUT busy indication
//   r*/p*/s*, go*     : one-hot moves and round-start strobes to the DUT
// master = environment side (move source + DUT), slave = sequencer side.
interface rps_move_sequencer_if;

   logic       push1_valid;
   logic [1:0] push1_move;
   logic       push1_ready;
   logic       push2_valid;
   logic [1:0] push2_move;
   logic       push2_ready;
   logic       dut_busy;
   logic       r1, p1, s1;
   logic       r2, p2, s2;
   logic       go1, go2;

   modport master (
      output push1_valid, push1_move, push2_valid, push2_move, dut_busy,
      input  push1_ready, push2_ready,
      input  r1, p1, s1, r2, p2, s2, go1, go2
   );

   modport slave (
      input  push1_valid, push1_move, push2_valid, push2_move, dut_busy,
      output push1_ready, push2_ready,
      output r1, p1, s1, r2, p2, s2, go1, go2
   );

endinterface

// File: rtl/rps_move_sequencer_fifo.sv
// Per-player move FIFO.
//   clk, rst        : clock, synchronous active-low reset
//   push, push_move : write request (ignored when full)
//   pop, pop_move   : read request (ignored when empty), head-of-queue move
//   full, empty     : occupancy flags derived from the internal count
// DEPTH must be a power of two so the pointers wrap naturally.
module rps_move_fifo
   import rps_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  move_e push_move,
   input  logic  pop,
   output move_e pop_move,
   output logic  full,
   output logic  empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   move_e            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   // Full is judged before any same-cycle pop, so a full FIFO always rejects.
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_move = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_move;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rps_move_sequencer.sv
// Round sequencer feeding rps_dut: queues moves per player, issues one round
// at a time and tracks the DUT busy handshake.
//   clk, rst     : clock, synchronous active-low reset
//   bus          : push ports, dut_busy, one-hot moves and go strobes
//   rounds       : completed-round count (wraps)
//   timeout_err  : sticky, DUT never raised dut_busy after a go
//   illegal_push : sticky, a NONE move was offered on either push port
//
// state        | meaning
// ST_IDLE      | waiting for both FIFOs non-empty and DUT idle
// ST_ISSUE     | go1/go2 high for this single cycle, moves driven
// ST_WAIT_BUSY | waiting for dut_busy to rise, timeout counter running
// ST_WAIT_DONE | DUT scoring, waiting for dut_busy to fall
module rps_move_sequencer
   import rps_types_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   rps_move_sequencer_if.slave  bus,
   output logic [CNT_W-1:0]     rounds,
   output logic                 timeout_err,
   output logic                 illegal_push
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   seq_state_e       state;
   logic [2:0]       mv1_oh;
   logic [2:0]       mv2_oh;
   logic             go;
   logic [WAIT_W-1:0] wait_cnt;

   logic  full1, empty1, full2, empty2;
   logic  wr1, wr2;
   logic  bad1, bad2;
   logic  start;
   move_e head1, head2;

   // NONE moves never reach the FIFO, so they cannot consume a slot.
   assign bad1  = bus.push1_valid && (bus.push1_move == NONE);
   assign bad2  = bus.push2_valid && (bus.push2_move == NONE);
   assign wr1   = bus.push1_valid && !bad1;
   assign wr2   = bus.push2_valid && !bad2;
   assign start = (state == ST_IDLE) && !empty1 && !empty2 && !bus.dut_busy;

   assign bus.push1_ready = !full1;
   assign bus.push2_ready = !full2;

   rps_move_fifo #(.DEPTH(DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst       (rst),
      .push      (wr1),
      .push_move (move_e'(bus.push1_move)),
      .pop       (start),
      .pop_move  (head1),
      .full      (full1),
      .empty     (empty1)
   );

   rps_move_fifo #(.DEPTH(DEPTH)) u_fifo2 (
      .clk       (clk),
      .rst       (rst),
      .push      (wr2),
      .push_move (move_e'(bus.push2_move)),
      .pop       (start),
      .pop_move  (head2),
      .full      (full2),
      .empty     (empty2)
   );

   assign {bus.r1, bus.p1, bus.s1} = mv1_oh;
   assign {bus.r2, bus.p2, bus.s2} = mv2_oh;
   assign bus.go1 = go;
   assign bus.go2 = go;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         mv1_oh       <= '0;
         mv2_oh       <= '0;
         go           <= 1'b0;
         wait_cnt     <= '0;
         rounds       <= '0;
         timeout_err  <= 1'b0;
         illegal_push <= 1'b0;
      end else begin
         go <= 1'b0;
         if (bad1 || bad2) begin
            illegal_push <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mv1_oh <= move_to_onehot(head1);
                  mv2_oh <= move_to_onehot(head2);
                  go     <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= '0;
               state    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (bus.dut_busy) begin
                  state <= ST_WAIT_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  // This edge is the one where the count reaches TIMEOUT.
                  if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                     timeout_err <= 1'b1;
                     mv1_oh      <= '0;
                     mv2_oh      <= '0;
                     state       <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!bus.dut_busy) begin
                  rounds <= rounds + 1'b1;
                  mv1_oh <= '0;
                  mv2_oh <= '0;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rps_move_sequencer.sv
// Scoreboard bench for rps_move_sequencer: the main process pushes moves and
// queues the expected round outputs; a monitor pops and compares on each go.
module tb_rps_move_sequencer;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] rounds;
   logic             timeout_err;
   logic             illegal_push;

   rps_move_sequencer_if bus ();

   rps_move_sequencer #(
      .DEPTH   (4),
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .rounds       (rounds),
      .timeout_err  (timeout_err),
      .illegal_push (illegal_push)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;
   logic [5:0] cur_rps;
   bit         hold_chk  = 1'b0;
   bit         seen_busy = 1'b0;
   int         busy_mode = 0;   // 0: busy 3 cycles, 1: never busy, 2: busy 10 cycles
   int         mt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // {r, p, s} for 01 rock, 10 paper, 11 scissors
   function automatic logic [2:0] oh(input logic [1:0] m);
      case (m)
         2'b01:   return 3'b100;
         2'b10:   return 3'b010;
         2'b11:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [7:0] outs();
      return {bus.go1, bus.go2, bus.r1, bus.p1, bus.s1, bus.r2, bus.p2, bus.s2};
   endfunction

   task automatic expect_round(input logic [1:0] m1, input logic [1:0] m2);
      exp_q.push_back({2'b11, oh(m1), oh(m2)});
   endtask

   task automatic push(input bit do1, input logic [1:0] m1, input bit do2, input logic [1:0] m2);
      int t;
      t = 0;
      while (((do1 && !bus.push1_ready) || (do2 && !bus.push2_ready)) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("push_ready_wait", 1, 0);
      bus.push1_valid = do1;
      bus.push1_move  = m1;
      bus.push2_valid = do2;
      bus.push2_move  = m2;
      @(posedge clk);
      #1;
      bus.push1_valid = 1'b0;
      bus.push2_valid = 1'b0;
   endtask

   task automatic wait_rounds(input int v);
      int t;
      t = 0;
      while (rounds !== CNT_W'(v) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("rounds", 32'(rounds), v);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // DUT model: answers a go with dut_busy starting the following cycle.
   initial begin
      bus.dut_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.go1 && busy_mode != 1) begin
            @(posedge clk);
            #1 bus.dut_busy = 1'b1;
            repeat (busy_mode == 2 ? 10 : 3) @(posedge clk);
            #1 bus.dut_busy = 1'b0;
         end
      end
   end

   // Monitor: each go pops one expected round; moves must hold while busy.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.go1 || bus.go2) begin
            if (exp_q.size() == 0) begin
               check("unexpected_go", {30'd0, bus.go1, bus.go2}, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("round_outputs", outs(), mon_e);
               cur_rps   = mon_e[5:0];
               hold_chk  = 1'b1;
               seen_busy = 1'b0;
            end
         end else if (hold_chk && bus.dut_busy) begin
            seen_busy = 1'b1;
            check("moves_held", outs(), {2'b00, cur_rps});
         end else if (hold_chk && seen_busy) begin
            hold_chk = 1'b0;
         end
      end
   end

   initial begin
      bus.push1_valid = 1'b0;
      bus.push1_move  = 2'b00;
      bus.push2_valid = 1'b0;
      bus.push2_move  = 2'b00;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset_ready", {bus.push1_ready, bus.push2_ready}, 2'b11);
      check("reset_outputs", outs(), 0);
      check("reset_flags", {timeout_err, illegal_push}, 0);
      check("reset_rounds", 32'(rounds), 0);

      // Single round, rock vs scissors, with push-to-go latency.
      expect_round(2'b01, 2'b11);
      push(1'b1, 2'b01, 1'b1, 2'b11);
      @(negedge clk);
      check("latency_go_low", bus.go1, 0);
      @(negedge clk);
      check("latency_go_high", {bus.go1, bus.go2}, 2'b11);
      wait_rounds(1);
      check("idle_moves_cleared", outs(), 0);

      // Fill P1 only: no round, full rejects a fifth push.
      push(1'b1, 2'b10, 1'b0, 2'b00);
      push(1'b1, 2'b01, 1'b0, 2'b00);
      push(1'b1, 2'b11, 1'b0, 2'b00);
      push(1'b1, 2'b10, 1'b0, 2'b00);
      check("p1_full_ready", bus.push1_ready, 0);
      bus.push1_valid = 1'b1;
      bus.push1_move  = 2'b01;
      @(posedge clk);
      #1 bus.push1_valid = 1'b0;
      idle(10);
      expect_round(2'b10, 2'b01);
      push(1'b0, 2'b00, 1'b1, 2'b01);
      wait_rounds(2);
      check("p1_ready_after_pop", bus.push1_ready, 1);
      push(1'b1, 2'b01, 1'b0, 2'b00);
      check("p1_full_again", bus.push1_ready, 0);
      expect_round(2'b01, 2'b10);
      expect_round(2'b11, 2'b11);
      expect_round(2'b10, 2'b01);
      expect_round(2'b01, 2'b10);
      push(1'b0, 2'b00, 1'b1, 2'b10);
      push(1'b0, 2'b00, 1'b1, 2'b11);
      push(1'b0, 2'b00, 1'b1, 2'b01);
      push(1'b0, 2'b00, 1'b1, 2'b10);
      wait_rounds(6);

      // Illegal move on P2 is dropped.
      push(1'b0, 2'b00, 1'b1, 2'b00);
      check("illegal_flag", illegal_push, 1);
      check("illegal_p2_ready", bus.push2_ready, 1);
      push(1'b1, 2'b11, 1'b0, 2'b00);
      idle(8);

      // DUT never responds.
      busy_mode = 1;
      expect_round(2'b11, 2'b10);
      push(1'b0, 2'b00, 1'b1, 2'b10);
      mt = 0;
      while (!bus.go1 && mt < 10) begin
         @(negedge clk);
         mt++;
      end
      check("timeout_go_seen", bus.go1, 1);
      mt = 0;
      while (!timeout_err && mt < 40) begin
         @(negedge clk);
         mt++;
      end
      check("timeout_latency", mt, 17);
      check("timeout_rounds", 32'(rounds), 6);
      check("timeout_moves_cleared", outs(), 0);
      busy_mode = 0;
      expect_round(2'b01, 2'b01);
      push(1'b1, 2'b01, 1'b1, 2'b01);
      wait_rounds(7);
      check("timeout_sticky", timeout_err, 1);

      // Reset while in WAIT_DONE with two moves still queued per player.
      busy_mode = 2;
      expect_round(2'b01, 2'b10);
      push(1'b1, 2'b01, 1'b1, 2'b10);
      push(1'b1, 2'b10, 1'b1, 2'b11);
      push(1'b1, 2'b11, 1'b1, 2'b01);
      mt = 0;
      while (!bus.dut_busy && mt < 20) begin
         @(negedge clk);
         mt++;
      end
      check("reset_mid_busy_seen", bus.dut_busy, 1);
      repeat (2) @(negedge clk);
      hold_chk = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_reset_outputs", outs(), 0);
      check("mid_reset_rounds", 32'(rounds), 0);
      check("mid_reset_flags", {timeout_err, illegal_push}, 0);
      check("mid_reset_ready", {bus.push1_ready, bus.push2_ready}, 2'b11);
      idle(20);
      busy_mode = 0;

      // Round counter wrap at 2^CNT_W.
      for (int i = 1; i <= 16; i++) begin
         expect_round(2'b10, 2'b11);
         push(1'b1, 2'b10, 1'b1, 2'b11);
         wait_rounds(i % 16);
      end

      idle(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rps_move_sequencer.md
# rps_move_sequencer

Upstream stage of `rps_dut`: buffers queued moves for player 1 and player 2 and issues one round at a time. For each round it drives the one-hot `r/p/s` lines and the `go1`/`go2` strobes, then tracks `dut_busy` until the DUT finishes scoring. It counts completed rounds and flags a DUT that never responds.

## Interface
Parameters:
- `DEPTH`, 4: entries per player move FIFO (power of two, ≥2)
- `TIMEOUT`, 16: max cycles in WAIT_BUSY before the error is flagged
- `CNT_W`, 16: width of the round counter

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-low
- `push1_valid` in 1: player 1 move offered
- `push1_move` in 2: player 1 move; encoding 00 = none (illegal), 01 = rock, 10 = paper, 11 = scissors
- `push1_ready` out 1: player 1 FIFO can accept a move
- `push2_valid`, `push2_move`, `push2_ready`: same as player 1, for player 2
- `dut_busy` in 1: from `rps_dut`; high while the round is being scored
- `r1 p1 s1` out 1 each: player 1 one-hot move to the DUT
- `r2 p2 s2` out 1 each: player 2 one-hot move to the DUT
- `go1 go2` out 1 each: round-start strobes
- `rounds` out CNT_W: completed-round count
- `timeout_err` out 1: sticky; DUT never raised `dut_busy`
- `illegal_push` out 1: sticky; a move with encoding 00 was offered

## Operation
- Each player has its own FIFO.
  - A push is accepted when valid and ready are both high at the clock edge.
  - `ready = !full`. A pop in the same cycle does not free space, so a full FIFO rejects the push.
  - A push with move 00 is dropped (never written) and sets `illegal_push`. It does not consume a slot.
- FSM states:
  - IDLE: leave when both FIFOs are non-empty and `dut_busy` = 0. Pop both FIFOs, latch the moves, go to ISSUE.
  - ISSUE: lasts one cycle. `go1` = `go2` = 1. Always go to WAIT_BUSY.
  - WAIT_BUSY:
    - If `dut_busy` = 1, go to WAIT_DONE.
    - Otherwise increment the wait counter. When it reaches TIMEOUT, set `timeout_err` and go to IDLE. `rounds` is not incremented.
  - WAIT_DONE: if `dut_busy` = 0, increment `rounds` (wraps modulo 2^CNT_W) and go to IDLE.
- Move outputs:
  - The latched one-hot moves are held on `r/p/s` from ISSUE through WAIT_DONE.
  - All `r/p/s` are 0 in IDLE.
  - Exactly one of `r1/p1/s1` is high in any non-IDLE state; likewise for player 2.
- The wait counter clears on entry to WAIT_BUSY. It needs width $clog2(TIMEOUT+1).
- Sticky flags clear only on reset.

## Timing
- Reset (`rst` = 0 at an edge): on the next cycle,
  - FSM is in IDLE and FIFOs are empty;
  - `push*_ready` = 1;
  - all `r/p/s`, `go*`, `timeout_err`, `illegal_push` = 0;
  - `rounds` = 0.
- Reset mid-round discards the latched moves and all FIFO contents. No `go` is emitted afterwards until new moves arrive.
- Push-to-issue latency: a move pushed at edge N sits in the FIFO after N. If the other FIFO is also non-empty and `dut_busy` = 0, the FSM pops at edge N+1, and `go` and `r/p/s` are high in cycle N+1..N+2.
- `go` is high for exactly one cycle per round. It never asserts while `dut_busy` is sampled high in IDLE.
- `rounds` updates on the edge that leaves WAIT_DONE.
- Timeout: `timeout_err` rises TIMEOUT cycles after ISSUE if `dut_busy` stayed 0.
- Back-to-back rounds: minimum spacing is 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE).
- One FIFO empty: the FSM waits in IDLE indefinitely. No partial round is issued.

## Structure
- Shared package `rps_types_pkg`:
  - `move_e` enum (NONE, ROCK, PAPER, SCISSORS; 2-bit);
  - `seq_state_e` enum;
  - function `move_to_onehot`.
- Sub-module `rps_move_fifo` (DEPTH entries × 2 bits, push/pop, full/empty, count), instantiated once per player.
- Top module contains the FSM, move latches, wait counter, round counter and sticky flags.

## Test plan
- Reset, then push P1 = ROCK and P2 = SCISSORS, with the DUT model raising `dut_busy` 1 cycle after `go` for 3 cycles → one `go` pulse, `r1` = 1 and `s2` = 1 held until busy falls, then `rounds` = 1.
- Push 4 moves to P1 only → P1 ready drops after the 4th push, no `go` ever fires. Then push 1 to P2 → exactly one round, P1 count = 3.
- DUT model never raises `dut_busy` → `timeout_err` = 1 after 16 cycles, `rounds` = 0, FSM back in IDLE. The next round proceeds normally.
- Push move 00 on P2 → `illegal_push` = 1, P2 FIFO stays empty, no `go`.
- Reset asserted in WAIT_DONE with 2 moves queued per player → all outputs zero, `rounds` = 0. No `go` until new pushes arrive.
- Preload `rounds` to 0xFFFF via 65535 rounds (or a forced start) and complete one more round → `rounds` = 0.
